shift_add_multiplier: RTL and testbench

Sequential shift-and-add unit computing P = Q*B + R, the inverse of the team's repeated-subtraction divider. It takes a quotient, divisor and remainder and reconstructs the dividend. Used on the datapath to rebuild operands, and by verification as a hardware cross-check of divider outputs (P must equal the original dividend). Start/Done handshake matches the divider's.

---
 rtl/shift_add_multiplier_if.sv | 24 ++
 rtl/shift_add_multiplier.sv | 100 ++++++++++
 tb/tb_shift_add_multiplier.sv | 203 ++++++++++++++++++++
 3 files changed

// File: rtl/shift_add_multiplier_if.sv
// shift_add_multiplier_if: operand/result bundle for the shift-and-add multiplier
//   q, b, r  : quotient, divisor and remainder operands (sampled on accepted start)
//   start    : operation request
//   p        : result q*b+r, valid while done
//   done     : result valid
//   busy     : operation in progress
//   ovf      : result does not fit WIDTH bits
//   rem_ok   : r < b (legal divider remainder)
interface shift_add_multiplier_if #(
    parameter int WIDTH = 8
);
    logic [WIDTH-1:0]   q;
    logic [WIDTH-1:0]   b;
    logic [WIDTH-1:0]   r;
    logic               start;
    logic [2*WIDTH-1:0] p;
    logic               done;
    logic               busy;
    logic               ovf;
    logic               rem_ok;

    modport master (output q, b, r, start, input p, done, busy, ovf, rem_ok);
    modport slave  (input q, b, r, start, output p, done, busy, ovf, rem_ok);
endinterface

// File: rtl/shift_add_multiplier.sv
// shift_add_multiplier: sequential P = Q*B + R, rebuilds a dividend from divider outputs
//   clk_i  : system clock, all state changes on the rising edge
//   rst_ni : synchronous active-low reset, aborts any operation
//   bus    : slave side of shift_add_multiplier_if (operands, start, result, status)
module shift_add_multiplier #(
    parameter int WIDTH = 8
) (
    input logic                   clk_i,
    input logic                   rst_ni,
    shift_add_multiplier_if.slave bus
);
    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t             state_q, state_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [2*WIDTH-1:0] mcand_q, mcand_d;
    logic [WIDTH-1:0]   mplier_q, mplier_d;
    logic [2*WIDTH-1:0] p_q, p_d;
    logic               done_q, done_d;
    logic               busy_q, busy_d;
    logic               ovf_q, ovf_d;
    logic               rem_ok_q, rem_ok_d;
    logic [2*WIDTH-1:0] acc_sum;

    // The maximum result is 2^(2W) - 2^W, so this add never wraps.
    assign acc_sum = acc_q + (mplier_q[0] ? mcand_q : '0);

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            acc_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            p_q      <= '0;
            done_q   <= 1'b0;
            busy_q   <= 1'b0;
            ovf_q    <= 1'b0;
            rem_ok_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            acc_q    <= acc_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            p_q      <= p_d;
            done_q   <= done_d;
            busy_q   <= busy_d;
            ovf_q    <= ovf_d;
            rem_ok_q <= rem_ok_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        acc_d    = acc_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        p_d      = p_q;
        done_d   = done_q;
        busy_d   = busy_q;
        ovf_d    = ovf_q;
        rem_ok_d = rem_ok_q;
        if (state_q == RUN) begin
            acc_d    = acc_sum;
            mcand_d  = mcand_q << 1;
            mplier_d = mplier_q >> 1;
            cnt_d    = cnt_q + CW'(1);
            // Fixed latency: no early exit once the multiplier runs out of ones.
            if (cnt_q == LAST) begin
                state_d = DONE;
                p_d     = acc_sum;
                done_d  = 1'b1;
                busy_d  = 1'b0;
                ovf_d   = |acc_sum[2*WIDTH-1:WIDTH];
            end
        end else if (bus.start) begin
            state_d  = RUN;
            cnt_d    = '0;
            acc_d    = {{WIDTH{1'b0}}, bus.r};
            mcand_d  = {{WIDTH{1'b0}}, bus.b};
            mplier_d = bus.q;
            rem_ok_d = bus.r < bus.b;
            done_d   = 1'b0;
            busy_d   = 1'b1;
            ovf_d    = 1'b0;
        end
    end

    assign bus.p      = p_q;
    assign bus.done   = done_q;
    assign bus.busy   = busy_q;
    assign bus.ovf    = ovf_q;
    assign bus.rem_ok = rem_ok_q;
endmodule

// File: tb/tb_shift_add_multiplier.sv
// tb_shift_add_multiplier: directed-vector bench for shift_add_multiplier
//   drives the interface directly, checks reset, latency, results, hold, ignored start,
//   mid-run reset and back-to-back operation against divider-derived triples
module tb_shift_add_multiplier;
    localparam int W = 8;

    typedef struct {
        logic [W-1:0]   q;
        logic [W-1:0]   b;
        logic [W-1:0]   r;
        logic [2*W-1:0] p;
        logic           ovf;
        logic           rem_ok;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   tests = 0;
    int   failed = 0;

    shift_add_multiplier_if #(.WIDTH(W)) bus ();

    shift_add_multiplier #(.WIDTH(W)) dut (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Launch one operation and check that done rises exactly WIDTH edges after acceptance.
    task automatic run_op(input logic [W-1:0] q, input logic [W-1:0] b, input logic [W-1:0] r,
                          input string tag);
        @(negedge clk);
        bus.q = q;
        bus.b = b;
        bus.r = r;
        bus.start = 1'b1;
        @(posedge clk);
        #1;
        chk({tag, " busy"}, 32'(bus.busy), 1);
        chk({tag, " done_low"}, 32'(bus.done), 0);
        @(negedge clk);
        bus.start = 1'b0;
        repeat (W - 1) @(posedge clk);
        #1;
        chk({tag, " not_early"}, 32'(bus.done), 0);
        @(posedge clk);
        #1;
        chk({tag, " done"}, 32'(bus.done), 1);
        chk({tag, " busy_low"}, 32'(bus.busy), 0);
    endtask

    vec_t tbl[10];

    initial begin
        int a, bb, seen;
        tbl[0] = '{q: 8'd13,  b: 8'd7,   r: 8'd4,   p: 16'd95,    ovf: 1'b0, rem_ok: 1'b1};
        tbl[1] = '{q: 8'd255, b: 8'd255, r: 8'd254, p: 16'hFEFF,  ovf: 1'b1, rem_ok: 1'b1};
        tbl[2] = '{q: 8'd0,   b: 8'd9,   r: 8'd5,   p: 16'd5,     ovf: 1'b0, rem_ok: 1'b1};
        tbl[3] = '{q: 8'd9,   b: 8'd0,   r: 8'd5,   p: 16'd5,     ovf: 1'b0, rem_ok: 1'b0};
        tbl[4] = '{q: 8'd1,   b: 8'd3,   r: 8'd3,   p: 16'd6,     ovf: 1'b0, rem_ok: 1'b0};
        tbl[5] = '{q: 8'd20,  b: 8'd12,  r: 8'd3,   p: 16'd243,   ovf: 1'b0, rem_ok: 1'b1};
        tbl[6] = '{q: 8'd16,  b: 8'd16,  r: 8'd0,   p: 16'd256,   ovf: 1'b1, rem_ok: 1'b1};
        tbl[7] = '{q: 8'd100, b: 8'd2,   r: 8'd1,   p: 16'd201,   ovf: 1'b0, rem_ok: 1'b1};
        tbl[8] = '{q: 8'd17,  b: 8'd15,  r: 8'd14,  p: 16'd269,   ovf: 1'b1, rem_ok: 1'b1};
        tbl[9] = '{q: 8'd128, b: 8'd1,   r: 8'd200, p: 16'd328,   ovf: 1'b1, rem_ok: 1'b0};

        bus.q = 8'd55;
        bus.b = 8'd66;
        bus.r = 8'd7;
        bus.start = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst p", 32'(bus.p), 0);
        chk("rst done", 32'(bus.done), 0);
        chk("rst busy", 32'(bus.busy), 0);
        chk("rst ovf", 32'(bus.ovf), 0);
        chk("rst rem_ok", 32'(bus.rem_ok), 0);
        @(negedge clk);
        bus.start = 1'b0;
        rst_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("idle busy", 32'(bus.busy), 0);
        chk("idle done", 32'(bus.done), 0);

        for (int i = 0; i < 10; i++) begin
            run_op(tbl[i].q, tbl[i].b, tbl[i].r, $sformatf("vec%0d", i));
            chk($sformatf("vec%0d p", i), 32'(bus.p), 32'(tbl[i].p));
            chk($sformatf("vec%0d ovf", i), 32'(bus.ovf), 32'(tbl[i].ovf));
            chk($sformatf("vec%0d rem_ok", i), 32'(bus.rem_ok), 32'(tbl[i].rem_ok));
            if (i == 0) begin
                for (int c = 0; c < 5; c++) begin
                    @(posedge clk);
                    #1;
                    chk("hold done", 32'(bus.done), 1);
                    chk("hold p", 32'(bus.p), 95);
                    chk("hold rem_ok", 32'(bus.rem_ok), 1);
                end
            end
        end

        @(negedge clk);
        bus.q = 8'd20;
        bus.b = 8'd12;
        bus.r = 8'd3;
        bus.start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.start = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        bus.q = 8'd1;
        bus.b = 8'd1;
        bus.r = 8'd1;
        bus.start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.start = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        chk("ign not_early", 32'(bus.done), 0);
        @(posedge clk);
        #1;
        chk("ign done", 32'(bus.done), 1);
        chk("ign p", 32'(bus.p), 243);

        @(negedge clk);
        bus.q = 8'd13;
        bus.b = 8'd7;
        bus.r = 8'd4;
        bus.start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.start = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        chk("abort p", 32'(bus.p), 0);
        chk("abort done", 32'(bus.done), 0);
        chk("abort busy", 32'(bus.busy), 0);
        chk("abort rem_ok", 32'(bus.rem_ok), 0);
        @(negedge clk);
        rst_n = 1'b1;
        seen = 0;
        repeat (12) begin
            @(posedge clk);
            #1;
            if (bus.done) seen++;
        end
        chk("abort no_done", 32'(seen), 0);

        a = 0;
        @(negedge clk);
        bb = $urandom_range(255, 1);
        a = $urandom_range(255, 0);
        bus.q = 8'(a / bb);
        bus.b = 8'(bb);
        bus.r = 8'(a % bb);
        bus.start = 1'b1;
        @(posedge clk);
        for (int i = 0; i < 200; i++) begin
            int exp_a;
            exp_a = a;
            @(negedge clk);
            if (i == 199) begin
                bus.start = 1'b0;
            end else begin
                bb = $urandom_range(255, 1);
                a = $urandom_range(255, 0);
                bus.q = 8'(a / bb);
                bus.b = 8'(bb);
                bus.r = 8'(a % bb);
            end
            repeat (W - 1) @(posedge clk);
            #1;
            chk("b2b not_early", 32'(bus.done), 0);
            @(posedge clk);
            #1;
            chk("b2b done", 32'(bus.done), 1);
            chk("b2b p", 32'(bus.p), 32'(exp_a));
            chk("b2b ovf", 32'(bus.ovf), 0);
            chk("b2b rem_ok", 32'(bus.rem_ok), 1);
            @(posedge clk);
            #1;
            if (i != 199) chk("b2b relaunch", 32'(bus.done), 0);
        end

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end
endmodule
